// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide engine: shift-add multiply, restoring divide.
// One operation in flight; busy stalls the pipeline, done pulses when hi/lo update.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic             is_div_reg;
    logic             neg_lo_reg;
    logic             neg_r_reg;
    logic             div0_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] mreg_reg;
    logic [WIDTH-1:0] opb_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             done_reg;

    logic             is_signed;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mreg_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        is_signed = ~op[0];
        abs_a     = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        abs_b     = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

        // Multiply: acc holds the running high half, mreg shifts the multiplier out / product in.
        mul_sum   = {1'b0, acc_reg} + (mreg_reg[0] ? {1'b0, opb_reg} : '0);

        // Divide: partial remainder in acc, dividend bits shift out of mreg as quotient bits shift in.
        div_shift = {acc_reg, mreg_reg[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opb_reg});
        div_diff  = div_shift[WIDTH-1:0] - opb_reg;

        if (is_div_reg) begin
            acc_next  = div_ge ? div_diff : div_shift[WIDTH-1:0];
            mreg_next = {mreg_reg[WIDTH-2:0], div_ge};
        end else begin
            acc_next  = mul_sum[WIDTH:1];
            mreg_next = {mul_sum[0], mreg_reg[WIDTH-1:1]};
        end

        prod_fix = neg_lo_reg ? (~{acc_reg, mreg_reg} + (2*WIDTH)'(1)) : {acc_reg, mreg_reg};
        quot_fix = neg_lo_reg ? (~mreg_reg + WIDTH'(1)) : mreg_reg;
        // With a zero divisor the remainder ends as |a|; re-applying a's sign restores raw a.
        rem_fix  = neg_r_reg ? (~acc_reg + WIDTH'(1)) : acc_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            is_div_reg <= 1'b0;
            neg_lo_reg <= 1'b0;
            neg_r_reg  <= 1'b0;
            div0_reg   <= 1'b0;
            acc_reg    <= '0;
            mreg_reg   <= '0;
            opb_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        is_div_reg <= op[1];
                        neg_lo_reg <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r_reg  <= is_signed && op[1] && a[WIDTH-1];
                        div0_reg   <= op[1] && (b == '0);
                        acc_reg    <= '0;
                        mreg_reg   <= abs_a;
                        opb_reg    <= abs_b;
                        cnt_reg    <= '0;
                        state_reg  <= CALC;
                    end
                end
                CALC: begin
                    acc_reg  <= acc_next;
                    mreg_reg <= mreg_next;
                    cnt_reg  <= cnt_reg + CW'(1);
                    if (cnt_reg == CW'(WIDTH - 1))
                        state_reg <= FIX;
                end
                FIX: begin
                    if (!is_div_reg) begin
                        hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_reg <= prod_fix[WIDTH-1:0];
                    end else if (div0_reg) begin
                        hi_reg <= rem_fix;
                        lo_reg <= '1;
                    end else begin
                        hi_reg <= rem_fix;
                        lo_reg <= quot_fix;
                    end
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: latency, results, ignored/back-to-back starts, async reset.
module tb_mul_div_unit;
    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Issue one op; counts edges from the accepting edge (inclusive) until done is seen.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int pulse_at);
        int n;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        check({tag, " busy_after_accept"}, 64'(busy), 64'd1);
        while (!done && n < 100) begin
            if (n == pulse_at) begin
                start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(n), 64'd34);
        check({tag, " busy_in_done"}, 64'(busy), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, 64'(done), 64'd0);
        check({tag, " lo_held"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int n;
        logic stable;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);
        @(negedge clk); rst = 1'b0;

        run_op("mul -3*5", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, -1);
        run_op("divu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, -1);
        run_op("div -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, -1);
        run_op("divu by0", 2'b11, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, -1);
        run_op("div by0 neg", 2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, -1);
        run_op("div min/-1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, -1);
        run_op("mul min*min", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, -1);
        run_op("mulu max*max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 10);

        // Back-to-back: start held high through the done cycle.
        op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        n = 1;
        op = 2'b00; a = 32'hFFFFFFFD; b = 32'd5;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b first latency", 64'(n), 64'd34);
        check("b2b first result", {hi, lo}, {32'd2, 32'd14});
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        check("b2b second accepted", 64'(busy), 64'd1);
        stable = 1'b1;
        while (!done && n < 100) begin
            if (hi !== 32'd2 || lo !== 32'd14) stable = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check("b2b first held", 64'(stable), 64'd1);
        check("b2b second latency", 64'(n), 64'd34);
        check("b2b second result", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFF1});

        // Async reset mid-operation.
        op = 2'b10; a = 32'hFFFFFFF9; b = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (n < 16) begin
            @(posedge clk); #1;
            n++;
        end
        #2 rst = 1'b1;
        #1;
        check("async rst busy", 64'(busy), 64'd0);
        check("async rst done", 64'(done), 64'd0);
        check("async rst hilo", {hi, lo}, 64'd0);
        @(negedge clk); rst = 1'b0;
        run_op("post-rst mulu 6*7", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
